// File: rtl/pipe_reg_chain.sv
// Parametrised stall/flush pipeline register chain: stall propagates backward,
// a bubble is injected below the lowest stalled stage, and flush kills are counted.
module pipe_reg_chain #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4,
  parameter int CW     = $clog2(STAGES + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  in_data,
  output logic              in_ready,
  input  logic [STAGES-1:0] stall,
  input  logic [STAGES-1:0] flush,
  output logic              out_valid,
  output logic [WIDTH-1:0]  out_data,
  output logic [STAGES-1:0] stage_valid,
  output logic [CW-1:0]     occupancy,
  output logic [7:0]        flush_count
);

  logic [STAGES-1:0] vld_q, vld_d;
  logic [STAGES-1:0] hold;
  logic [WIDTH-1:0]  data_q [STAGES];
  logic [WIDTH-1:0]  data_d [STAGES];
  logic [7:0]        fcnt_q, fcnt_d;

  function automatic logic [3:0] popcount(input logic [STAGES-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < STAGES; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [3:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {5'b00000, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  // A stall anywhere downstream freezes every earlier stage.
  always_comb begin
    hold = '0;
    hold[STAGES-1] = stall[STAGES-1];
    for (int k = STAGES - 2; k >= 0; k--) hold[k] = stall[k] | hold[k+1];
  end

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    if (flush[0]) begin
      vld_d[0]  = 1'b0;
      data_d[0] = '0;
    end else if (!hold[0]) begin
      vld_d[0]  = in_valid;
      data_d[0] = in_valid ? in_data : '0;
    end
    // Stage k reads pre-edge stage k-1, so a flush of k-1 never reaches k this edge.
    for (int k = 1; k < STAGES; k++) begin
      if (flush[k]) begin
        vld_d[k]  = 1'b0;
        data_d[k] = '0;
      end else if (!hold[k]) begin
        if (hold[k-1]) begin
          vld_d[k]  = 1'b0;
          data_d[k] = '0;
        end else begin
          vld_d[k]  = vld_q[k-1];
          data_d[k] = data_q[k-1];
        end
      end
    end
    fcnt_d = sat_add8(fcnt_q, popcount(flush & vld_q));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_q  <= '0;
      fcnt_q <= '0;
      for (int k = 0; k < STAGES; k++) data_q[k] <= '0;
    end else begin
      vld_q  <= vld_d;
      fcnt_q <= fcnt_d;
      for (int k = 0; k < STAGES; k++) data_q[k] <= data_d[k];
    end
  end

  assign in_ready    = ~hold[0];
  assign out_valid   = vld_q[STAGES-1];
  assign out_data    = data_q[STAGES-1];
  assign stage_valid = vld_q;
  assign occupancy   = CW'(popcount(vld_q));
  assign flush_count = fcnt_q;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed self-checking bench for pipe_reg_chain (WIDTH=32, STAGES=4).
module tb_pipe_reg_chain;

  localparam int WIDTH  = 32;
  localparam int STAGES = 4;
  localparam int CW     = $clog2(STAGES + 1);

  logic              clock;
  logic              reset;
  logic              in_valid;
  logic [WIDTH-1:0]  in_data;
  logic              in_ready;
  logic [STAGES-1:0] stall;
  logic [STAGES-1:0] flush;
  logic              out_valid;
  logic [WIDTH-1:0]  out_data;
  logic [STAGES-1:0] stage_valid;
  logic [CW-1:0]     occupancy;
  logic [7:0]        flush_count;

  int n_chk;
  int n_fail;

  pipe_reg_chain #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .stall(stall), .flush(flush), .out_valid(out_valid),
    .out_data(out_data), .stage_valid(stage_valid), .occupancy(occupancy),
    .flush_count(flush_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic ov, input logic [31:0] od,
                           input logic [3:0] sv, input logic [2:0] occ, input logic [7:0] fc);
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(ov));
    chk({tag, ".out_data"}, 64'(out_data), 64'(od));
    chk({tag, ".stage_valid"}, 64'(stage_valid), 64'(sv));
    chk({tag, ".occupancy"}, 64'(occupancy), 64'(occ));
    chk({tag, ".flush_count"}, 64'(flush_count), 64'(fc));
  endtask

  // Advance one edge and sample shortly after it; invalid output must carry zero data.
  task automatic step();
    @(posedge clock);
    #1;
    if (!out_valid) chk("inv_out_data_zero", 64'(out_data), 64'd0);
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    reset = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    stall = '0;
    flush = '0;

    #2;
    chk_state("reset", 1'b0, 32'h0, 4'h0, 3'd0, 8'd0);
    chk("reset.in_ready", 64'(in_ready), 64'd1);
    stall = 4'b0100;
    #1;
    chk("reset.in_ready_stalled", 64'(in_ready), 64'd0);
    stall = '0;
    @(posedge clock);
    #1;
    chk_state("reset_edge", 1'b0, 32'h0, 4'h0, 3'd0, 8'd0);
    reset = 1'b1;

    // Streaming
    in_valid = 1'b1; in_data = 32'h11; step();
    chk_state("stream1", 1'b0, 32'h0, 4'b0001, 3'd1, 8'd0);
    in_data = 32'h22; step();
    in_data = 32'h33; step();
    chk_state("stream3", 1'b0, 32'h0, 4'b0111, 3'd3, 8'd0);
    in_data = 32'h44; step();
    chk_state("stream4", 1'b1, 32'h11, 4'b1111, 3'd4, 8'd0);
    in_data = 32'h55; step();
    chk_state("stream5", 1'b1, 32'h22, 4'b1111, 3'd4, 8'd0);

    // Mid stall on stage 1 for two cycles
    stall = 4'b0010; in_data = 32'h66;
    #1;
    chk("stall.in_ready", 64'(in_ready), 64'd0);
    step();
    chk_state("stall1", 1'b1, 32'h33, 4'b1011, 3'd3, 8'd0);
    chk("stall1.in_ready", 64'(in_ready), 64'd0);
    step();
    chk_state("stall2", 1'b0, 32'h0, 4'b0011, 3'd2, 8'd0);
    stall = '0;
    #1;
    chk("unstall.in_ready", 64'(in_ready), 64'd1);
    step();
    chk_state("drain1", 1'b0, 32'h0, 4'b0111, 3'd3, 8'd0);
    in_data = 32'h77; step();
    chk_state("drain2", 1'b1, 32'h44, 4'b1111, 3'd4, 8'd0);
    in_data = 32'h88; step();
    chk_state("drain3", 1'b1, 32'h55, 4'b1111, 3'd4, 8'd0);

    // Flush stage 2 while stage 3 stalls: s3=55 s2=66 s1=77 s0=88
    stall = 4'b1000; flush = 4'b0100; in_data = 32'h99;
    #1;
    chk("fh.in_ready", 64'(in_ready), 64'd0);
    step();
    chk_state("flush_hold", 1'b1, 32'h55, 4'b1011, 3'd3, 8'd1);

    // Flush stage 1 while everything advances: s3=55 s2=- s1=77 s0=88
    stall = '0; flush = 4'b0010; in_data = 32'h99; step();
    chk_state("flush_adv", 1'b0, 32'h0, 4'b0101, 3'd2, 8'd2);
    flush = '0; in_data = 32'hAA; step();
    chk_state("flush_adv_next", 1'b1, 32'h77, 4'b1011, 3'd3, 8'd2);

    // Flushing an invalid stage adds nothing
    flush = 4'b0100; in_data = 32'hBB; step();
    chk_state("flush_invalid", 1'b0, 32'h0, 4'b0011, 3'd2, 8'd2);
    flush = '0; in_data = 32'hCC; step();
    in_data = 32'hDD; step();
    chk_state("refill", 1'b1, 32'hAA, 4'b1111, 3'd4, 8'd2);

    // Saturation: count is 2, each full flush adds 4
    for (int i = 1; i <= 65; i++) begin
      flush = 4'b1111; step();
      if (i == 1) chk_state("sat_first", 1'b0, 32'h0, 4'b0000, 3'd0, 8'd6);
      if (i == 63) chk("sat_63", 64'(flush_count), 64'd254);
      if (i == 64) chk("sat_64", 64'(flush_count), 64'd255);
      if (i == 65) chk("sat_65", 64'(flush_count), 64'd255);
      flush = '0;
      for (int j = 0; j < 4; j++) begin
        in_data = 32'(i * 16 + j); step();
      end
    end
    chk_state("sat_full", 1'b1, 32'h0000_0410, 4'b1111, 3'd4, 8'd255);

    // Async reset between edges with the pipe full
    #1;
    reset = 1'b0;
    #1;
    chk_state("async_reset", 1'b0, 32'h0, 4'h0, 3'd0, 8'd0);
    chk("async_reset.in_ready", 64'(in_ready), 64'd1);
    #1;
    reset = 1'b1;
    in_valid = 1'b1; in_data = 32'hEE; step();
    chk_state("post_reset1", 1'b0, 32'h0, 4'b0001, 3'd1, 8'd0);
    in_valid = 1'b0; in_data = 32'h0;
    step();
    step();
    chk_state("post_reset3", 1'b0, 32'h0, 4'b0100, 3'd1, 8'd0);
    step();
    chk_state("post_reset4", 1'b1, 32'hEE, 4'b1000, 3'd1, 8'd0);
    step();
    chk_state("post_reset5", 1'b0, 32'h0, 4'b0000, 3'd0, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
